// File: rtl/deco_seq_pkg.sv
// Shared constants, state encoding and dwell helper for the decoder select sequencer.
package deco_seq_pkg;

    localparam int SEL_W   = 3;
    localparam int NUM_OUT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        STEP
    } state_t;

    // A zero dwell would never expire, so it is promoted to a single cycle.
    function automatic logic [31:0] eff_dwell(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Down-counter that times how long each select code is held.
module dwell_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         reload,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] count;

    assign expire = (count == W'(1)) && !load;

    // reload lets the counter restart itself on expiry without a combinational path back through load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load || (expire && reload)) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/deco_sel_sequencer.sv
// Drives the 3-to-8 decoder select and enable, either sweeping all codes or stepping on request.
module deco_sel_sequencer
    import deco_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_code,
    output logic               req_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               wrap,
    output logic               busy
);

    state_t             state;
    state_t             next_state;
    logic               go_scan;
    logic               go_step;
    logic               expire;
    logic [DWELL_W-1:0] load_value;
    logic [SEL_W-1:0]   sel_d;
    logic               en_d;
    logic               wrap_d;
    logic               busy_d;

    assign req_ready  = (state == IDLE) && !mode;
    assign go_scan    = (state == IDLE) && mode && start && !stop;
    assign go_step    = (state == IDLE) && req_valid && req_ready && !stop;
    assign load_value = DWELL_W'(eff_dwell(32'(dwell)));

    dwell_counter #(
        .W(DWELL_W)
    ) u_dwell_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (go_scan || go_step),
        .reload     (state == SCAN),
        .load_value (load_value),
        .expire     (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // stop wins over every other event in SCAN and STEP.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (go_scan) begin
                    next_state = SCAN;
                end else if (go_step) begin
                    next_state = STEP;
                end
            end
            SCAN: begin
                if (stop) begin
                    next_state = IDLE;
                end
            end
            STEP: begin
                if (stop || expire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel;
        wrap_d = 1'b0;
        en_d   = (next_state != IDLE);
        busy_d = en_d;
        if (go_scan) begin
            sel_d = '0;
        end else if (go_step) begin
            sel_d = req_code;
        end else if ((state == SCAN) && !stop && expire) begin
            sel_d  = sel + SEL_W'(1);
            wrap_d = (sel == SEL_W'(NUM_OUT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= '0;
            en   <= 1'b0;
            wrap <= 1'b0;
            busy <= 1'b0;
        end else begin
            sel  <= sel_d;
            en   <= en_d;
            wrap <= wrap_d;
            busy <= busy_d;
        end
    end

endmodule

// File: tb/tb_deco_sel_sequencer.sv
// Scoreboard bench for deco_sel_sequencer: stimulus queues the expected outputs, a monitor checks them after each edge.
module tb_deco_sel_sequencer;

    typedef struct {
        int         id;
        logic [2:0] sel;
        logic       en;
        logic       wrap;
        logic       busy;
        logic       ready;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic       req_valid;
    logic [2:0] req_code;
    logic       req_ready;
    logic [2:0] sel;
    logic       en;
    logic       wrap;
    logic       busy;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   vec_id;

    deco_sel_sequencer #(
        .DWELL_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .dwell     (dwell),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .sel       (sel),
        .en        (en),
        .wrap      (wrap),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int id, input logic [2:0] s, input logic e,
                                input logic w, input logic r);
        exp_t x;
        x.id    = id;
        x.sel   = s;
        x.en    = e;
        x.wrap  = w;
        x.busy  = e;
        x.ready = r;
        return x;
    endfunction

    task automatic checkOutput(input exp_t e);
        tests += 5;
        if (sel !== e.sel) begin
            fails++;
            $display("[TB] FAIL vec%0d sel: got %0d expected %0d", e.id, sel, e.sel);
        end
        if (en !== e.en) begin
            fails++;
            $display("[TB] FAIL vec%0d en: got %0b expected %0b", e.id, en, e.en);
        end
        if (wrap !== e.wrap) begin
            fails++;
            $display("[TB] FAIL vec%0d wrap: got %0b expected %0b", e.id, wrap, e.wrap);
        end
        if (busy !== e.busy) begin
            fails++;
            $display("[TB] FAIL vec%0d busy: got %0b expected %0b", e.id, busy, e.busy);
        end
        if (req_ready !== e.ready) begin
            fails++;
            $display("[TB] FAIL vec%0d req_ready: got %0b expected %0b", e.id, req_ready, e.ready);
        end
    endtask

    // Inputs change on the falling edge; the expectation describes outputs after the next rising edge.
    task automatic applyStimulus(input logic m, input logic st, input logic sp, input logic [7:0] dw,
                                 input logic rv, input logic [2:0] rc,
                                 input logic [2:0] e_sel, input logic e_en, input logic e_wrap);
        @(negedge clk);
        mode      = m;
        start     = st;
        stop      = sp;
        dwell     = dw;
        req_valid = rv;
        req_code  = rc;
        vec_id++;
        exp_q.push_back(mk(vec_id, e_sel, e_en, e_wrap, !e_en && !m));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        vec_id    = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        dwell     = 8'd0;
        req_valid = 1'b0;
        req_code  = 3'd0;

        @(negedge clk);
        #1;
        checkOutput(mk(1000, 3'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        // Full sweep with dwell 3: sel returns to 0 with wrap on cycle 25.
        for (int c = 1; c <= 26; c++) begin
            applyStimulus(1'b1, (c == 1), 1'b0, 8'd3, 1'b0, 3'd0,
                          3'((c - 1) / 3), 1'b1, (c == 25));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        // Reset asserted while sel=5 mid-scan.
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(1'b1, (c == 1), 1'b0, 8'd3, 1'b0, 3'd0,
                          3'((c - 1) / 3), 1'b1, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput(mk(1001, 3'd0, 1'b0, 1'b0, 1'b0));
        mode = 1'b0;
        #1;
        checkOutput(mk(1002, 3'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        // Dwell 0 acts as 1, then dwell changes take effect at the next code.
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(1'b1, (c == 1), 1'b0, 8'd0, 1'b0, 3'd0,
                          3'(c - 1), 1'b1, (c == 9));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0);
        // Stop coincides with the expiry of code 3; start+stop together in IDLE does nothing.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0);

        // Single step of code 6 for 4 cycles, second request (code 2) held valid.
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'd4, 1'b1, (c == 1) ? 3'd6 : 3'd2,
                          3'd6, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 3'd2, 3'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 3'd2, 3'd2, 1'b1, 1'b0);
        // mode flips to 1 mid-step; the step still runs its full dwell.
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 3'd5, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 3'd5, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 3'd5, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        // One-cycle step with dwell 0, then a step aborted by stop.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd3, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 3'd4, 3'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 3'd1, 3'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
